rocc_cmd_resp_decoupler: RTL and testbench

- Sits between the core's RoCC port and a RoCC accelerator, such as the accumulator black box.
- Buffers commands core->accelerator and responses accelerator->core in independent FIFOs, so the core and the accelerator never share a combinational ready/valid path.
- Limits the number of in-flight commands that expect a response (xd=1), drives the aggregate busy signal to the core, and flags stray responses from the accelerator.

---
 rtl/rocc_decoupler_pkg.sv | 29 ++
 rtl/rocc_sync_fifo.sv | 54 +++++
 rtl/rocc_cmd_resp_decoupler.sv | 131 +++++++++++++
 tb/tb_rocc_cmd_resp_decoupler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rocc_decoupler_pkg.sv
// Shared RoCC field offsets and FIFO entry layouts for the command/response decoupler.
package rocc_decoupler_pkg;

  localparam int ROCC_XLEN       = 64;
  localparam int ROCC_REG_W      = 5;
  localparam int ROCC_INST_W     = 32;

  localparam int ROCC_FUNCT_LSB  = 25;
  localparam int ROCC_RS2_LSB    = 20;
  localparam int ROCC_RS1_LSB    = 15;
  localparam int ROCC_XD_BIT     = 14;
  localparam int ROCC_XS1_BIT    = 13;
  localparam int ROCC_XS2_BIT    = 12;
  localparam int ROCC_RD_LSB     = 7;
  localparam int ROCC_OPCODE_LSB = 0;

  // Entry layouts are sized by ROCC_XLEN; the decoupler's XLEN must match it.
  typedef struct packed {
    logic [ROCC_INST_W-1:0] inst;
    logic [ROCC_XLEN-1:0]   rs1;
    logic [ROCC_XLEN-1:0]   rs2;
  } rocc_cmd_t;

  typedef struct packed {
    logic [ROCC_REG_W-1:0] rd;
    logic [ROCC_XLEN-1:0]  data;
  } rocc_resp_t;

endpackage

// File: rtl/rocc_sync_fifo.sv
// Single-clock FIFO with registered occupancy; head is read straight from storage (no flow-through).
module rocc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count alone decides what is visible.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rocc_cmd_resp_decoupler.sv
// Decouples a core RoCC port from an accelerator with one FIFO per direction,
// bounds in-flight xd=1 commands, aggregates busy and flags stray responses.
module rocc_cmd_resp_decoupler
  import rocc_decoupler_pkg::*;
#(
  parameter int XLEN            = ROCC_XLEN,
  parameter int CMD_DEPTH       = 4,
  parameter int RESP_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clock,
  input  logic            reset,

  input  logic            core_cmd_valid,
  output logic            core_cmd_ready,
  input  logic [31:0]     core_cmd_inst,
  input  logic [XLEN-1:0] core_cmd_rs1,
  input  logic [XLEN-1:0] core_cmd_rs2,

  output logic            acc_cmd_valid,
  input  logic            acc_cmd_ready,
  output logic [31:0]     acc_cmd_inst,
  output logic [XLEN-1:0] acc_cmd_rs1,
  output logic [XLEN-1:0] acc_cmd_rs2,

  input  logic            acc_resp_valid,
  output logic            acc_resp_ready,
  input  logic [4:0]      acc_resp_rd,
  input  logic [XLEN-1:0] acc_resp_data,

  output logic            core_resp_valid,
  input  logic            core_resp_ready,
  output logic [4:0]      core_resp_rd,
  output logic [XLEN-1:0] core_resp_data,

  input  logic            acc_busy,
  output logic            core_busy,
  output logic            err_stray_resp
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  rocc_cmd_t  cmd_in, cmd_head;
  rocc_resp_t resp_in, resp_head;

  logic          cmd_full, cmd_empty, cmd_push, cmd_pop;
  logic          resp_full, resp_empty, resp_push, resp_pop;
  logic          acc_accept, xd_push, cmd_xd;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] pending;

  assign cmd_xd         = core_cmd_inst[ROCC_XD_BIT];
  assign core_cmd_ready = !cmd_full && !(cmd_xd && (outstanding == OW'(MAX_OUTSTANDING)));
  assign cmd_push       = core_cmd_valid && core_cmd_ready;
  assign xd_push        = cmd_push && cmd_xd;

  assign cmd_in.inst = core_cmd_inst;
  assign cmd_in.rs1  = core_cmd_rs1;
  assign cmd_in.rs2  = core_cmd_rs2;

  assign acc_cmd_valid = !cmd_empty;
  assign cmd_pop       = acc_cmd_valid && acc_cmd_ready;
  assign acc_cmd_inst  = cmd_head.inst;
  assign acc_cmd_rs1   = cmd_head.rs1;
  assign acc_cmd_rs2   = cmd_head.rs2;

  rocc_sync_fifo #(
    .WIDTH ($bits(rocc_cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (cmd_push),
    .push_data (cmd_in),
    .pop       (cmd_pop),
    .full      (cmd_full),
    .empty     (cmd_empty),
    .head      (cmd_head)
  );

  // Stray responses are still handshaken so the accelerator never stalls on them.
  assign acc_resp_ready = !resp_full;
  assign acc_accept     = acc_resp_valid && acc_resp_ready;
  assign resp_push      = acc_accept && (pending != '0);

  assign resp_in.rd   = acc_resp_rd;
  assign resp_in.data = acc_resp_data;

  assign core_resp_valid = !resp_empty;
  assign resp_pop        = core_resp_valid && core_resp_ready;
  assign core_resp_rd    = resp_head.rd;
  assign core_resp_data  = resp_head.data;

  rocc_sync_fifo #(
    .WIDTH ($bits(rocc_resp_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (resp_push),
    .push_data (resp_in),
    .pop       (resp_pop),
    .full      (resp_full),
    .empty     (resp_empty),
    .head      (resp_head)
  );

  assign core_busy = !cmd_empty || (outstanding != '0) || acc_busy;

  // outstanding retires when the core takes the response; pending when the accelerator delivers it.
  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding    <= '0;
      pending        <= '0;
      err_stray_resp <= 1'b0;
    end else begin
      case ({xd_push, resp_pop})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
      case ({xd_push, resp_push})
        2'b10:   pending <= pending + OW'(1);
        2'b01:   pending <= pending - OW'(1);
        default: pending <= pending;
      endcase
      err_stray_resp <= acc_accept && (pending == '0);
    end
  end

endmodule

// File: tb/tb_rocc_cmd_resp_decoupler.sv
// Directed self-checking bench for rocc_cmd_resp_decoupler with hand-computed expectations.
module tb_rocc_cmd_resp_decoupler;

  localparam int XLEN = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic            core_cmd_valid, core_cmd_ready;
  logic [31:0]     core_cmd_inst;
  logic [XLEN-1:0] core_cmd_rs1, core_cmd_rs2;
  logic            acc_cmd_valid, acc_cmd_ready;
  logic [31:0]     acc_cmd_inst;
  logic [XLEN-1:0] acc_cmd_rs1, acc_cmd_rs2;
  logic            acc_resp_valid, acc_resp_ready;
  logic [4:0]      acc_resp_rd;
  logic [XLEN-1:0] acc_resp_data;
  logic            core_resp_valid, core_resp_ready;
  logic [4:0]      core_resp_rd;
  logic [XLEN-1:0] core_resp_data;
  logic            acc_busy, core_busy, err_stray_resp;

  int checks = 0;
  int errors = 0;

  rocc_cmd_resp_decoupler #(
    .XLEN            (XLEN),
    .CMD_DEPTH       (4),
    .RESP_DEPTH      (4),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .core_cmd_valid  (core_cmd_valid),
    .core_cmd_ready  (core_cmd_ready),
    .core_cmd_inst   (core_cmd_inst),
    .core_cmd_rs1    (core_cmd_rs1),
    .core_cmd_rs2    (core_cmd_rs2),
    .acc_cmd_valid   (acc_cmd_valid),
    .acc_cmd_ready   (acc_cmd_ready),
    .acc_cmd_inst    (acc_cmd_inst),
    .acc_cmd_rs1     (acc_cmd_rs1),
    .acc_cmd_rs2     (acc_cmd_rs2),
    .acc_resp_valid  (acc_resp_valid),
    .acc_resp_ready  (acc_resp_ready),
    .acc_resp_rd     (acc_resp_rd),
    .acc_resp_data   (acc_resp_data),
    .core_resp_valid (core_resp_valid),
    .core_resp_ready (core_resp_ready),
    .core_resp_rd    (core_resp_rd),
    .core_resp_data  (core_resp_data),
    .acc_busy        (acc_busy),
    .core_busy       (core_busy),
    .err_stray_resp  (err_stray_resp)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Step past the next rising edge; inputs are then changed and outputs sampled 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] exp_inst;

  initial begin
    reset           = 1'b1;
    core_cmd_valid  = 1'b0;
    core_cmd_inst   = '0;
    core_cmd_rs1    = '0;
    core_cmd_rs2    = '0;
    acc_cmd_ready   = 1'b0;
    acc_resp_valid  = 1'b0;
    acc_resp_rd     = '0;
    acc_resp_data   = '0;
    core_resp_ready = 1'b1;
    acc_busy        = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_acc_cmd_valid", 64'(acc_cmd_valid), 64'd0);
    check("rst_core_resp_valid", 64'(core_resp_valid), 64'd0);
    check("rst_err", 64'(err_stray_resp), 64'd0);
    check("rst_busy0", 64'(core_busy), 64'd0);
    acc_busy = 1'b1; settle();
    check("rst_busy_follows_acc", 64'(core_busy), 64'd1);
    acc_busy = 1'b0;
    reset = 1'b0;

    // Single xd=1 round trip
    core_cmd_valid = 1'b1;
    core_cmd_inst  = 32'h0000_400B;
    core_cmd_rs1   = 64'd5;
    core_cmd_rs2   = 64'd7;
    acc_cmd_ready  = 1'b1;
    settle();
    check("rt_cmd_ready", 64'(core_cmd_ready), 64'd1);
    check("rt_no_flowthrough", 64'(acc_cmd_valid), 64'd0);
    tick();
    core_cmd_valid = 1'b0;
    settle();
    check("rt_acc_cmd_valid", 64'(acc_cmd_valid), 64'd1);
    check("rt_acc_inst", 64'(acc_cmd_inst), 64'h400B);
    check("rt_acc_rs1", acc_cmd_rs1, 64'd5);
    check("rt_acc_rs2", acc_cmd_rs2, 64'd7);
    check("rt_busy_cmd", 64'(core_busy), 64'd1);
    tick();
    acc_resp_valid = 1'b1;
    acc_resp_rd    = 5'd3;
    acc_resp_data  = 64'h1234;
    settle();
    check("rt_acc_cmd_popped", 64'(acc_cmd_valid), 64'd0);
    check("rt_busy_outstanding", 64'(core_busy), 64'd1);
    check("rt_resp_ready", 64'(acc_resp_ready), 64'd1);
    tick();
    acc_resp_valid = 1'b0;
    settle();
    check("rt_core_resp_valid", 64'(core_resp_valid), 64'd1);
    check("rt_core_resp_rd", 64'(core_resp_rd), 64'd3);
    check("rt_core_resp_data", core_resp_data, 64'h1234);
    check("rt_busy_until_pop", 64'(core_busy), 64'd1);
    check("rt_no_err", 64'(err_stray_resp), 64'd0);
    tick();
    check("rt_resp_drained", 64'(core_resp_valid), 64'd0);
    check("rt_busy_clear", 64'(core_busy), 64'd0);

    // Cmd FIFO full with xd=0 commands, then in-order drain
    acc_cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      core_cmd_valid = 1'b1;
      core_cmd_inst  = 32'h0000_000B | (32'(i) << 25);
      core_cmd_rs1   = 64'(i + 10);
      core_cmd_rs2   = 64'(i + 20);
      settle();
      check($sformatf("fill_ready_%0d", i), 64'(core_cmd_ready), 64'd1);
      tick();
    end
    core_cmd_inst = 32'h0000_000B | (32'd4 << 25);
    settle();
    check("full_ready_low", 64'(core_cmd_ready), 64'd0);
    acc_cmd_ready = 1'b1;
    settle();
    check("full_pop_no_free", 64'(core_cmd_ready), 64'd0);
    core_cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_inst = 32'h0000_000B | (32'(i) << 25);
      settle();
      check($sformatf("drain_valid_%0d", i), 64'(acc_cmd_valid), 64'd1);
      check($sformatf("drain_inst_%0d", i), 64'(acc_cmd_inst), 64'(exp_inst));
      check($sformatf("drain_rs1_%0d", i), acc_cmd_rs1, 64'(i + 10));
      check($sformatf("drain_rs2_%0d", i), acc_cmd_rs2, 64'(i + 20));
      tick();
    end
    check("drain_empty", 64'(acc_cmd_valid), 64'd0);
    check("drain_ready_back", 64'(core_cmd_ready), 64'd1);
    check("drain_busy_clear", 64'(core_busy), 64'd0);

    // Outstanding limit: four xd=1 in flight block a fifth, xd=0 still passes
    for (int i = 0; i < 4; i++) begin
      core_cmd_valid = 1'b1;
      core_cmd_inst  = 32'h0000_400B | (32'(i) << 7);
      settle();
      check($sformatf("xd_ready_%0d", i), 64'(core_cmd_ready), 64'd1);
      tick();
    end
    core_cmd_inst = 32'h0000_400B;
    settle();
    check("xd_limit_block", 64'(core_cmd_ready), 64'd0);
    core_cmd_inst = 32'h0000_000B;
    settle();
    check("xd0_still_ready", 64'(core_cmd_ready), 64'd1);
    tick();
    core_cmd_valid = 1'b0;
    acc_resp_valid = 1'b1;
    acc_resp_rd    = 5'd2;
    acc_resp_data  = 64'hAA;
    tick();
    acc_resp_valid = 1'b0;
    core_cmd_valid = 1'b1;
    core_cmd_inst  = 32'h0000_400B;
    settle();
    check("lim_resp_valid", 64'(core_resp_valid), 64'd1);
    check("lim_resp_rd", 64'(core_resp_rd), 64'd2);
    check("lim_still_blocked", 64'(core_cmd_ready), 64'd0);
    core_cmd_valid = 1'b0;
    tick();
    core_cmd_valid = 1'b1;
    settle();
    check("lim_fifth_accepted", 64'(core_cmd_ready), 64'd1);
    tick();
    core_cmd_valid = 1'b0;
    tick();

    // Mid-operation reset with 2 commands and 1 response buffered
    acc_cmd_ready   = 1'b0;
    core_resp_ready = 1'b0;
    core_cmd_valid  = 1'b1;
    core_cmd_inst   = 32'h0000_000B;
    tick(); tick();
    core_cmd_valid = 1'b0;
    acc_resp_valid = 1'b1;
    acc_resp_rd    = 5'd4;
    tick();
    acc_resp_valid = 1'b0;
    settle();
    check("pre_rst_cmd_valid", 64'(acc_cmd_valid), 64'd1);
    check("pre_rst_resp_valid", 64'(core_resp_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("mid_rst_cmd_valid", 64'(acc_cmd_valid), 64'd0);
    check("mid_rst_resp_valid", 64'(core_resp_valid), 64'd0);
    check("mid_rst_busy", 64'(core_busy), 64'd0);
    acc_busy = 1'b1; settle();
    check("mid_rst_busy_acc", 64'(core_busy), 64'd1);
    acc_busy = 1'b0;
    core_cmd_inst = 32'h0000_400B;
    settle();
    check("mid_rst_xd_ready", 64'(core_cmd_ready), 64'd1);

    // Stray response with pending == 0
    core_resp_ready = 1'b1;
    acc_resp_valid  = 1'b1;
    acc_resp_rd     = 5'd1;
    acc_resp_data   = 64'h55;
    settle();
    check("stray_ready", 64'(acc_resp_ready), 64'd1);
    check("stray_err_not_yet", 64'(err_stray_resp), 64'd0);
    tick();
    acc_resp_valid = 1'b0;
    settle();
    check("stray_err_pulse", 64'(err_stray_resp), 64'd1);
    check("stray_dropped", 64'(core_resp_valid), 64'd0);
    check("stray_no_busy", 64'(core_busy), 64'd0);
    tick();
    check("stray_err_one_cycle", 64'(err_stray_resp), 64'd0);
    check("stray_still_dropped", 64'(core_resp_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
